// File: rtl/mul_serial_arbiter.sv
// Round-robin arbiter that shares one bit-serial 4x4 multiplier among four requesters.
// It shifts the winner's operands in LSB first and collects the 8 serial product bits into PROD.
module mul_serial_arbiter #(
    parameter int OUT_LAT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  REQ,
    input  logic [15:0] OPA,
    input  logic [15:0] OPB,
    output logic [3:0]  GNT,
    output logic [3:0]  DONE,
    output logic [7:0]  PROD,
    output logic        BUSY,
    output logic        M_IE,
    output logic        M_A,
    output logic        M_B,
    input  logic        M_O
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [3:0] LAT_CNT  = 4'(OUT_LAT);
    localparam logic [3:0] LAST_CNT = 4'(OUT_LAT + 7);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic [1:0]  owner_r;
    logic [1:0]  last_r;
    logic [3:0]  opa_r;
    logic [3:0]  opb_r;
    logic [6:0]  prod_sh_r;
    logic [3:0]  gnt_r;
    logic [3:0]  done_r;
    logic [7:0]  prod_r;
    logic [1:0]  cand_s;
    logic [1:0]  win_s;
    logic        win_vld_s;
    logic        run_end_s;

    // Round-robin pick: walk offsets 4..1 so the nearest candidate after last_r overwrites the rest
    always_comb begin
        win_s     = last_r;
        win_vld_s = 1'b0;
        cand_s    = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            cand_s = last_r + 2'(i);
            if (REQ[cand_s]) begin
                win_s     = cand_s;
                win_vld_s = 1'b1;
            end else begin
                win_vld_s = win_vld_s;
            end
        end
    end

    assign run_end_s = (state_r == RUN) && (cnt_r == LAST_CNT);

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (win_vld_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (run_end_s) begin
                    state_nxt_s = FIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FIN:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            owner_r   <= 2'd0;
            last_r    <= 2'd3;
            opa_r     <= 4'd0;
            opb_r     <= 4'd0;
            prod_sh_r <= 7'd0;
            gnt_r     <= 4'd0;
            done_r    <= 4'd0;
            prod_r    <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= 4'd0;
            done_r  <= 4'd0;
            case (state_r)
                IDLE: begin
                    if (win_vld_s) begin
                        owner_r <= win_s;
                        cnt_r   <= 4'd0;
                        opa_r   <= OPA[{win_s, 2'b00} +: 4];
                        opb_r   <= OPB[{win_s, 2'b00} +: 4];
                        gnt_r   <= 4'b0001 << win_s;
                    end
                end
                RUN: begin
                    if (run_end_s) begin
                        // Final bit goes straight into PROD so it is valid in the FIN cycle
                        prod_r  <= {M_O, prod_sh_r};
                        done_r  <= 4'b0001 << owner_r;
                        last_r  <= owner_r;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                        if (cnt_r >= LAT_CNT) begin
                            prod_sh_r[3'(cnt_r - LAT_CNT)] <= M_O;
                        end
                    end
                end
                FIN:     cnt_r <= 4'd0;
                default: cnt_r <= 4'd0;
            endcase
        end
    end

    // Serial unit drive, decoded from registered state only
    always_comb begin
        M_IE = 1'b0;
        M_A  = 1'b0;
        M_B  = 1'b0;
        if ((state_r == RUN) && (cnt_r < 4'd4)) begin
            M_IE = 1'b1;
            M_A  = opa_r[cnt_r[1:0]];
            M_B  = opb_r[cnt_r[1:0]];
        end else begin
            M_IE = 1'b0;
        end
    end

    assign GNT  = gnt_r;
    assign DONE = done_r;
    assign PROD = prod_r;
    assign BUSY = (state_r != IDLE);

endmodule

// File: tb/tb_mul_serial_arbiter.sv
// Bench for mul_serial_arbiter: three instances (OUT_LAT 4, 1, 8), each with a causal serial multiplier model.
// A transaction-level round-robin/product model predicts winners, latencies and products.
module tb_mul_serial_arbiter;
    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req  [3];
    logic [15:0] opa  [3];
    logic [15:0] opb  [3];
    logic [3:0]  gnt  [3];
    logic [3:0]  done [3];
    logic [7:0]  prod [3];
    logic        busy [3];
    logic        m_ie [3];
    logic        m_a  [3];
    logic        m_b  [3];
    int          checks = 0;
    int          failures = 0;
    int          rr_last [3];

    always #5 CLK = ~CLK;

    function automatic int lat_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 8);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 4 : ((g == 1) ? 1 : 8);
        logic       mo_s = 1'b0;
        logic [3:0] a_acc = 4'd0;
        logic [3:0] b_acc = 4'd0;
        logic [7:0] p_v = 8'd0;
        int         age = 0;
        int         idx = 0;
        bit         active = 1'b0;

        mul_serial_arbiter #(.OUT_LAT(LAT)) u_dut (
            .CLK (CLK),
            .RST (rst),
            .REQ (req[g]),
            .OPA (opa[g]),
            .OPB (opb[g]),
            .GNT (gnt[g]),
            .DONE(done[g]),
            .PROD(prod[g]),
            .BUSY(busy[g]),
            .M_IE(m_ie[g]),
            .M_A (m_a[g]),
            .M_B (m_b[g]),
            .M_O (mo_s)
        );

        // Serial unit: product bit j depends only on operand bits 0..j, so it can be emitted causally
        always @(negedge CLK) begin
            if (rst) begin
                active = 1'b0;
                mo_s   = 1'b0;
            end else begin
                if (!active && m_ie[g]) begin
                    active = 1'b1;
                    age    = 0;
                    idx    = 0;
                    a_acc  = 4'd0;
                    b_acc  = 4'd0;
                end else if (active) begin
                    age++;
                end
                if (active && m_ie[g] && idx < 4) begin
                    a_acc[idx] = m_a[g];
                    b_acc[idx] = m_b[g];
                    idx++;
                end
                mo_s = 1'b0;
                if (active && age >= LAT && age <= LAT + 7) begin
                    p_v  = {4'd0, a_acc} * {4'd0, b_acc};
                    mo_s = p_v[age - LAT];
                end
                if (active && age >= LAT + 7) active = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic int rr_pick(input logic [3:0] mask, input int last);
        for (int i = 1; i <= 4; i++) begin
            if (mask[(last + i) % 4]) return (last + i) % 4;
        end
        return 0;
    endfunction

    task automatic check_zero(input int k);
        chk("rst_gnt", gnt[k], 0);
        chk("rst_done", done[k], 0);
        chk("rst_prod", prod[k], 0);
        chk("rst_busy", busy[k], 0);
        chk("rst_m_ie", m_ie[k], 0);
        chk("rst_m_a", m_a[k], 0);
        chk("rst_m_b", m_b[k], 0);
    endtask

    // One job on instance k with the current req[k]; returns the granted index seen on GNT
    task automatic do_job(input int k, input int exp_wait, output int won);
        int lat;
        int w;
        int n;
        logic [3:0] a;
        logic [3:0] b;
        lat = lat_of(k);
        w   = rr_pick(req[k], rr_last[k]);
        won = -1;
        n   = 0;
        do begin
            tick(1);
            n++;
        end while (gnt[k] == 4'd0 && n < 40);
        chk("gnt_wait", n, exp_wait);
        if (gnt[k] == 4'd0) return;
        chk("gnt", gnt[k], 4'b0001 << w);
        for (int i = 0; i < 4; i++) if (gnt[k][i]) won = i;
        req[k][won] = 1'b0;
        a = opa[k][4*w +: 4];
        b = opb[k][4*w +: 4];
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick(1);
            chk("m_ie", m_ie[k], 1);
            chk("m_a", m_a[k], a[i]);
            chk("m_b", m_b[k], b[i]);
        end
        n = 3;
        do begin
            tick(1);
            n++;
            if (n == 4) chk("m_ie_off", m_ie[k], 0);
        end while (done[k] == 4'd0 && n < 40);
        chk("done_lat", n, lat + 8);
        chk("done", done[k], 4'b0001 << w);
        chk("gnt_done_excl", gnt[k], 0);
        chk("prod", prod[k], a * b);
        chk("busy_fin", busy[k], 1);
        rr_last[k] = w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int won;
        int n;
        int seen;
        for (int k = 0; k < 3; k++) begin
            req[k] = 4'd0;
            opa[k] = 16'd0;
            opb[k] = 16'd0;
            rr_last[k] = 3;
        end
        rst = 1'b1;
        tick(3);
        for (int k = 0; k < 3; k++) check_zero(k);
        rst = 1'b0;
        tick(1);

        // Single job: 13 x 11
        opa[0] = 16'h000D;
        opb[0] = 16'h000B;
        req[0] = 4'b0001;
        do_job(0, 1, won);
        chk("single_win", won, 0);

        // Corner operands, ending on requester 3
        tick(1);
        opa[0] = 16'h0000; opb[0] = 16'h0090; req[0] = 4'b0010;
        do_job(0, 1, won);
        tick(1);
        opa[0] = 16'h0100; opb[0] = 16'h0100; req[0] = 4'b0100;
        do_job(0, 1, won);
        tick(1);
        opa[0] = 16'hF000; opb[0] = 16'hF000; req[0] = 4'b1000;
        do_job(0, 1, won);
        chk("corner_win", won, 3);

        // Round-robin with all requesters, each reasserting after its DONE
        tick(1);
        opa[0] = 16'(($urandom() & 32'hFFFF));
        opb[0] = 16'(($urandom() & 32'hFFFF));
        req[0] = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            do_job(0, (i == 0) ? 1 : 2, won);
            chk("rr_order", won, i % 4);
            if (won >= 0) req[0][won] = 1'b1;
        end
        req[0] = 4'b0000;

        // Contention after requester 2 completes
        tick(1);
        req[0] = 4'b0100;
        do_job(0, 1, won);
        req[0] = 4'b0101;
        do_job(0, 2, won);
        chk("contend_first", won, 0);
        do_job(0, 2, won);
        chk("contend_second", won, 2);

        // Reset mid-job at cnt=6
        tick(1);
        opa[0] = 16'h0005; opb[0] = 16'h0003; req[0] = 4'b0001;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (gnt[0] == 4'd0 && n < 40);
        chk("abort_gnt", gnt[0], 4'b0001);
        req[0] = 4'b0000;
        tick(6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) rr_last[k] = 3;
        check_zero(0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick(1);
            if (done[0] != 4'd0) seen++;
        end
        chk("abort_no_done", seen, 0);
        opa[0] = 16'h0090; opb[0] = 16'h00E0; req[0] = 4'b0010;
        do_job(0, 1, won);
        chk("after_abort_win", won, 1);

        // Latency extremes: 7 x 6 on OUT_LAT=1 and OUT_LAT=8
        for (int k = 1; k < 3; k++) begin
            opa[k] = 16'h0007; opb[k] = 16'h0006; req[k] = 4'b0001;
            do_job(k, 1, won);
        end

        // Randomized request masks and operands against the reference model
        for (int r = 0; r < 10; r++) begin
            tick($urandom_range(1, 3));
            opa[0] = 16'($urandom() & 32'hFFFF);
            opb[0] = 16'($urandom() & 32'hFFFF);
            req[0] = 4'($urandom_range(1, 15));
            n = 1;
            while (req[0] != 4'd0) begin
                do_job(0, n, won);
                n = 2;
                if (won < 0) req[0] = 4'd0;
            end
        end

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_serial_arbiter.md
# mul_serial_arbiter

Arbiter and sequencer that shares one bit-serial 4x4 multiplier unit among four requesters. Each requester presents two parallel 4-bit operands. The block picks a winner by round-robin and shifts the operands into the serial unit LSB first. It then collects the 8 serial product bits into a parallel result and returns it with a one-cycle done pulse. It sits between the client logic and the serial multiplier, and is the only driver of that unit's input enable and data lines.

## Interface
- OUT_LAT, default 4: cycles from the first M_IE cycle to the cycle in which product bit 0 is valid on M_O. Legal range 1..8.
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- REQ  in  4  per-requester request; held high until the matching GNT bit pulses.
- OPA  in  16  operand A; requester i uses OPA[4i+3:4i].
- OPB  in  16  operand B; requester i uses OPB[4i+3:4i].
- GNT  out  4  one-hot, one-cycle pulse marking acceptance of operands.
- DONE  out  4  one-hot, one-cycle pulse; PROD is valid for that requester.
- PROD  out  8  product of the last completed job; holds until the next DONE.
- BUSY  out  1  high whenever state is not IDLE.
- M_IE  out  1  serial unit input enable.
- M_A  out  1  serial operand A bit.
- M_B  out  1  serial operand B bit.
- M_O  in  1  serial product bit from the unit, LSB first.

## Operation
- FSM states: IDLE, RUN, FIN. Only one job is in flight at a time.
- IDLE: if REQ is nonzero, select winner w by round-robin and register OPA/OPB slice w into opa_r/opb_r. Load owner=w and cnt=0, then go to RUN.
- Round-robin search order is last+1, last+2, last+3, last (mod 4), where last is the most recently completed requester. last resets to 3, so requester 0 has first priority after reset.
- RUN: cnt increments every cycle.
  - M_IE=1 when cnt<4, with M_A=opa_r[cnt] and M_B=opb_r[cnt]. Otherwise M_IE=0 and M_A=M_B=0.
  - When OUT_LAT ≤ cnt ≤ OUT_LAT+7, M_O is sampled into prod_sh[cnt-OUT_LAT].
  - At cnt=OUT_LAT+7, go to FIN.
- FIN: PROD<=assembled product, DONE[owner]=1, last<=owner, then return to IDLE.
- Arbitration happens only in IDLE. Requests arriving in RUN or FIN wait.
- A REQ that drops after GNT does not cancel the job: it completes and DONE still pulses.
- REQ[i] still high in the cycle after its own GNT counts as a new request. Clients must deassert REQ on GNT.
- cnt is 4 bits wide and never wraps at legal OUT_LAT values.

## Timing
- Reset values: GNT=0, DONE=0, PROD=0, BUSY=0, M_IE=0, M_A=0, M_B=0. Internal state: IDLE, cnt=0, last=3.
- RST asserted mid-job aborts immediately. The next cycle shows reset values. A partial product is never reported, and the aborted requester must re-request.
- Assume REQ is sampled in IDLE at cycle t:
  - Cycle t+1: GNT[w] pulses; cnt=0 and the first M_IE cycle is in progress.
  - Cycles t+1..t+4: M_IE=1.
  - Cycle t+1+OUT_LAT+j: product bit j is sampled.
  - Cycle t+OUT_LAT+9: FIN, DONE[w]=1, and PROD is valid from this cycle.
  - Cycle t+OUT_LAT+10: IDLE; the earliest next arbitration.
- Back-to-back job period is OUT_LAT+10 cycles (14 at the default).
- GNT and DONE never assert in the same cycle. At most one bit of each is high.

## Test plan
- Single job: REQ=0001, OPA[3:0]=13, OPB[3:0]=11, bench serial model with OUT_LAT=4 → GNT=0001 at t+1. M_A sequence 1,0,1,1 and M_B sequence 1,1,0,1 on cycles t+1..t+4. DONE=0001 with PROD=143 at t+13.
- Corner operands: 15×15 → PROD=225; 0×9 → PROD=0; 1×1 → PROD=1.
- Round-robin: REQ=1111 held, each client deasserting on its own GNT and reasserting after DONE → grant order 0,1,2,3,0. No GNT arrives before the prior DONE.
- Contention after an owner: requester 2 completes, then REQ=0101 → requester 0 wins (search order 3,0,1,2). On the next job, requester 2 wins.
- Reset mid-job: RST for one cycle at cnt=6 → next cycle all outputs zero and no DONE. A new REQ=0010 then completes normally with the correct product.
- Latency parameter: OUT_LAT=1 and OUT_LAT=8 with 7×6 → PROD=42, and DONE arrives at t+10 and t+17 respectively.
